// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank: divisor limits, default
// counter width, divisor type and the high-phase length helper.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DIV_MIN   = 2;

    typedef logic [DEF_CNT_W-1:0] div_t;

    // High-phase length of a period of 'div' cycles; odd divisors get the extra cycle high.
    function automatic int unsigned half_len(input int unsigned div);
        return (div + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write channel of the clock divider bank.
//   cfg_valid : write request
//   cfg_ready : write accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch    : target channel index
//   cfg_div   : new divisor
//   cfg_err   : one-cycle pulse after a rejected write
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active divisor, single-entry pending
// divisor slot, registered divided clock and rising-edge tick.
//   clk_in, rst : clock, async active-high reset
//   en          : channel run enable
//   sync        : restart the period now (enabled channels only)
//   wr, wr_div  : load wr_div into the pending slot
//   pend_valid  : pending slot occupied
//   clk_out     : divided clock
//   tick        : one-cycle pulse with each clk_out rising edge
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DEF_DIV = 50
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend_valid,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;
    logic             wrap;

    // Period boundary detection and high-phase length of the active divisor.
    always_comb begin
        cnt_inc = cnt + CNT_W'(1);
        half    = CNT_W'(half_len(32'(div)));
        wrap    = (cnt == (div - CNT_W'(1))) || sync;
    end

    // Counter, divisor swap at boundaries, and pending slot.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt        <= CNT_W'(DEF_DIV - 1);
            div        <= CNT_W'(DEF_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            if (!en) begin
                // Parked one short of wrap so the first enabled edge starts a period.
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend_valid) begin
                    div <= pend_div;
                    cnt <= pend_div - CNT_W'(1);
                end else begin
                    cnt <= div - CNT_W'(1);
                end
            end else if (wrap) begin
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
                if (pend_valid) begin
                    div <= pend_div;
                end
            end else begin
                cnt     <= cnt_inc;
                clk_out <= (cnt_inc < half);
                tick    <= 1'b0;
            end

            // A write landing on the swap edge refills the slot after the old value is consumed.
            if (wr) begin
                pend_div   <= wr_div;
                pend_valid <= 1'b1;
            end else if (pend_valid && (!en || wrap)) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Runtime-programmable multi-channel integer clock divider.
//   clk_in, rst : input clock, async active-high reset
//   ch_en       : per-channel run enable
//   sync_pulse  : restart all enabled channels in phase
//   cfg         : divisor-write channel (slave side)
//   clk_out     : divided clocks
//   tick        : one-cycle pulse with each clk_out rising edge
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DEF_DIV = 50
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_pulse,
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PAD_W = 1 << CH_W;

    logic [NUM_CH-1:0] pend_valid;
    logic [NUM_CH-1:0] wr;
    logic [PAD_W-1:0]  pend_pad;
    logic              in_range;
    logic              div_ok;
    logic              ready;
    logic              accept;

    // Write decode; out-of-range indices are always ready so they can be rejected.
    always_comb begin
        pend_pad = PAD_W'(pend_valid);
        in_range = 32'(cfg.cfg_ch) < NUM_CH;
        div_ok   = 32'(cfg.cfg_div) >= DIV_MIN;
        ready    = in_range ? ~pend_pad[cfg.cfg_ch] : 1'b1;
        accept   = cfg.cfg_valid && ready;
        wr       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr[i] = accept && in_range && div_ok && (32'(cfg.cfg_ch) == i);
        end
    end

    assign cfg.cfg_ready = ready;

    // Rejected-write pulse.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= accept && !(in_range && div_ok);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in     (clk_in),
            .rst        (rst),
            .en         (ch_en[g]),
            .sync       (sync_pulse),
            .wr         (wr[g]),
            .wr_div     (cfg.cfg_div),
            .pend_valid (pend_valid[g]),
            .clk_out    (clk_out[g]),
            .tick       (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank with a time-based reference model:
// each channel is tracked as "cycles since last rising edge" against its
// divisor, plus a one-deep pending divisor slot.
module tb_clk_div_bank;

    localparam int NCH  = 5;
    localparam int CW   = 8;
    localparam int DDIV = 50;

    logic           clk_in = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic           sync_pulse;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

    clk_div_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DDIV)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .ch_en      (ch_en),
        .sync_pulse (sync_pulse),
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    int             m_div   [NCH];
    int             m_since [NCH];
    bit             m_run   [NCH];
    bit             m_pv    [NCH];
    int             m_pdiv  [NCH];
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;
    logic           m_err;
    bit             m_acc;

    function automatic bit m_ready();
        int ch;
        ch = int'(cfg_if.cfg_ch);
        if (ch >= NCH) return 1'b1;
        return !m_pv[ch];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]   = DDIV;
            m_since[i] = 0;
            m_run[i]   = 1'b0;
            m_pv[i]    = 1'b0;
            m_pdiv[i]  = 0;
        end
        m_clk  = '0;
        m_tick = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        bit bad;
        int ch;
        ch    = int'(cfg_if.cfg_ch);
        m_acc = cfg_if.cfg_valid && m_ready();
        bad   = (ch >= NCH) || (int'(cfg_if.cfg_div) < 2);
        for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) begin
                m_run[i]  = 1'b0;
                m_clk[i]  = 1'b0;
                m_tick[i] = 1'b0;
                if (m_pv[i]) begin
                    m_div[i] = m_pdiv[i];
                    m_pv[i]  = 1'b0;
                end
            end else if (!m_run[i] || sync_pulse || (m_since[i] + 1 >= m_div[i])) begin
                m_run[i]   = 1'b1;
                m_since[i] = 0;
                m_clk[i]   = 1'b1;
                m_tick[i]  = 1'b1;
                if (m_pv[i]) begin
                    m_div[i] = m_pdiv[i];
                    m_pv[i]  = 1'b0;
                end
            end else begin
                m_since[i] = m_since[i] + 1;
                m_clk[i]   = (m_since[i] < (m_div[i] + 1) / 2);
                m_tick[i]  = 1'b0;
            end
        end
        m_err = m_acc && bad;
        if (m_acc && !bad) begin
            m_pv[ch]   = 1'b1;
            m_pdiv[ch] = int'(cfg_if.cfg_div);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        if (!rst) model_step();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic do_write(input int ch, input int div);
        bit got;
        got = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_div   = 8'(div);
        for (int i = 0; i < 200; i++) begin
            if (m_ready()) got = 1'b1;
            cycle();
            if (got) break;
        end
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL write_timeout ch=%0d: write not accepted within 200 cycles", ch);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_en = '0;
        sync_pulse = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0;
        model_reset();
        repeat (2) @(negedge clk_in);
        n_chk++;
        if (clk_out !== '0 || tick !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: clk_out=%b tick=%b, required 0", clk_out, tick);
        end
        n_chk++;
        if (cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cfg: err=%b ready=%b, required err=0 ready=1",
                     cfg_if.cfg_err, cfg_if.cfg_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_default_period();
        int first, second, highs;
        first = -1; second = -1; highs = 0;
        ch_en = 5'b00001;
        for (int k = 1; k <= 130; k++) begin
            cycle();
            n_chk++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                n_fail++;
                $display("FAIL default_track cyc=%0d: clk_out=%b tick=%b, required %b %b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
            if (tick[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (first >= 0 && second < 0 && clk_out[0]) highs++;
        end
        n_chk++;
        if (first != 1) begin
            n_fail++;
            $display("FAIL default_first_tick: at %0d, required 1", first);
        end
        n_chk++;
        if (second - first != 50) begin
            n_fail++;
            $display("FAIL default_period: %0d, required 50", second - first);
        end
        n_chk++;
        if (highs != 25) begin
            n_fail++;
            $display("FAIL default_high_len: %0d, required 25", highs);
        end
    endtask

    task automatic test_reprogram();
        int t_en, t1, t2, highs;
        bit got;
        ch_en = 5'b00011;
        t_en = cyc;
        repeat (20) cycle();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 3'd1;
        cfg_if.cfg_div = 8'd5;
        #1;
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reprog_ready_first: %b, required 1", cfg_if.cfg_ready);
        end
        cycle();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            n_chk++;
            if (cfg_if.cfg_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL reprog_stall_ready cyc=%0d: %b, required %b",
                         cyc, cfg_if.cfg_ready, m_ready());
            end
            if (cfg_if.cfg_ready === 1'b1) begin
                got = 1'b1;
                n_chk++;
                if (tick[1] !== 1'b1 || cyc - t_en != 51) begin
                    n_fail++;
                    $display("FAIL reprog_boundary: tick1=%b at offset %0d, required 1 at 51",
                             tick[1], cyc - t_en);
                end
                cycle();
                break;
            end
            cycle();
            n_chk++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                n_fail++;
                $display("FAIL reprog_track cyc=%0d: clk_out=%b tick=%b, required %b %b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
        end
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL reprog_timeout: second write never accepted");
        end
        t1 = -1; t2 = -1; highs = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_chk++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                n_fail++;
                $display("FAIL reprog_track2 cyc=%0d: clk_out=%b tick=%b, required %b %b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
            if (tick[1]) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            if (t1 >= 0 && t2 < 0 && clk_out[1]) highs++;
        end
        n_chk++;
        if (t2 - t1 != 5 || highs != 3) begin
            n_fail++;
            $display("FAIL reprog_n5: period=%0d high=%0d, required 5 and 3", t2 - t1, highs);
        end
    endtask

    task automatic test_cfg_err();
        int t_en;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 3'd2;
        cfg_if.cfg_div = 8'd1;
        #1;
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_div_ready: %b, required 1", cfg_if.cfg_ready);
        end
        cycle();
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (cfg_if.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_div_pulse: %b, required 1", cfg_if.cfg_err);
        end
        cycle();
        n_chk++;
        if (cfg_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_div_clear: %b, required 0", cfg_if.cfg_err);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 3'(NCH);
        cfg_if.cfg_div = 8'd9;
        #1;
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_ch_ready: %b, required 1", cfg_if.cfg_ready);
        end
        cycle();
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (cfg_if.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_ch_pulse: %b, required 1", cfg_if.cfg_err);
        end
        // ch2 must still divide by the reset default
        ch_en = 5'b00111;
        t_en = cyc;
        for (int k = 1; k <= 52; k++) begin
            cycle();
            n_chk++;
            if (tick[2] !== ((k == 1) || (k == 51)) || cfg_if.cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_div_unchanged k=%0d: tick2=%b err=%b", k, tick[2], cfg_if.cfg_err);
            end
        end
    endtask

    task automatic test_sync();
        do_write(0, 4);
        do_write(1, 6);
        for (int k = 0; k < 60; k++) begin
            cycle();
            n_chk++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                n_fail++;
                $display("FAIL sync_pre cyc=%0d: clk_out=%b tick=%b, required %b %b",
                         cyc, clk_out, tick, m_clk, m_tick);
            end
        end
        for (int k = 0; k < 10 && m_since[0] != 1; k++) cycle();
        sync_pulse = 1'b1;
        cycle();
        sync_pulse = 1'b0;
        n_chk++;
        if (clk_out[1:0] !== 2'b11 || tick[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL sync_align: clk_out=%b tick=%b, required 11 11", clk_out[1:0], tick[1:0]);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle();
            n_chk++;
            if (tick[0] !== (k % 4 == 0) || tick[1] !== (k % 6 == 0) ||
                clk_out[0] !== ((k % 4) < 2) || clk_out[1] !== ((k % 6) < 3)) begin
                n_fail++;
                $display("FAIL sync_restart k=%0d: clk_out=%b tick=%b", k, clk_out[1:0], tick[1:0]);
            end
        end
        for (int k = 0; k < 10 && m_since[0] != 3; k++) cycle();
        sync_pulse = 1'b1;
        cycle();
        sync_pulse = 1'b0;
        n_chk++;
        if (tick[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_coincident: tick0=%b, required 1", tick[0]);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            n_chk++;
            if (tick[0] !== (k % 4 == 0) || tick !== m_tick || clk_out !== m_clk) begin
                n_fail++;
                $display("FAIL sync_single_wrap k=%0d: tick=%b clk_out=%b, required %b %b",
                         k, tick, clk_out, m_tick, m_clk);
            end
        end
    endtask

    task automatic test_enable_toggle();
        ch_en[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_ch = 3'd2;
                cfg_if.cfg_div = 8'd3;
            end
            cycle();
            cfg_if.cfg_valid = 1'b0;
            n_chk++;
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_low k=%0d: clk_out2=%b tick2=%b, required 0", k, clk_out[2], tick[2]);
            end
        end
        ch_en[2] = 1'b1;
        cycle();
        n_chk++;
        if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable_rise: clk_out2=%b tick2=%b, required 1 1", clk_out[2], tick[2]);
        end
        for (int k = 1; k <= 6; k++) begin
            cycle();
            n_chk++;
            if (tick[2] !== (k % 3 == 0) || clk_out[2] !== ((k % 3) < 2)) begin
                n_fail++;
                $display("FAIL reenable_n3 k=%0d: clk_out2=%b tick2=%b", k, clk_out[2], tick[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ch_en = '1;
        repeat (10) cycle();
        do_write(0, 30);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        cfg_if.cfg_ch = 3'd0;
        #1;
        n_chk++;
        if (clk_out !== '0 || tick !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: clk_out=%b tick=%b, required 0", clk_out, tick);
        end
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: %b, required 1", cfg_if.cfg_ready);
        end
        repeat (2) cycle();
        rst = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            cycle();
            n_chk++;
            if (tick[0] !== ((k == 1) || (k == 51)) || clk_out !== m_clk || tick !== m_tick) begin
                n_fail++;
                $display("FAIL midreset_default k=%0d: clk_out=%b tick=%b, required %b %b",
                         k, clk_out, tick, m_clk, m_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
            sync_pulse       = ($urandom_range(0, 19) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch    = 3'($urandom_range(0, 7));
            cfg_if.cfg_div   = 8'($urandom_range(0, 12));
            #1;
            n_chk++;
            if (cfg_if.cfg_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL rand_ready cyc=%0d: %b, required %b", cyc, cfg_if.cfg_ready, m_ready());
            end
            cycle();
            n_chk++;
            if (clk_out !== m_clk || tick !== m_tick || cfg_if.cfg_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_track cyc=%0d: clk_out=%b tick=%b err=%b, required %b %b %b",
                         cyc, clk_out, tick, cfg_if.cfg_err, m_clk, m_tick, m_err);
            end
        end
        sync_pulse = 1'b0;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_default_period();
        test_reprogram();
        test_cfg_err();
        test_sync();
        test_enable_toggle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
